// File: rtl/multicycle_control_unit_pkg.sv
// ctrl_pkg: state, opcode, ALU encodings and control word shared by the multi-cycle control unit
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH
  } state_t;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;
  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       iord;
    logic       memread;
    logic       mem_write;
    logic       memtoreg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;
  function automatic logic is_wait(state_t s);
    return s inside {FETCH, MEM_READ, MEM_WRITE};
  endfunction
endpackage

// File: rtl/multicycle_control_unit_ctrl_out_decode.sv
// ctrl_out_decode: combinational state to control-word decoder
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  // Moore strobes per state; only the FETCH PC/IR loads wait on memory
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread   = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      DECODE: ctrl.alu_src_b = SRCB_IMM;
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_R;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_I;
      end
      WB_ALU: ctrl.reg_write = 1'b1;
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memtoreg  = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle sequencer; MULTICYCLE_CTRL_PERF_CNT_EN adds the instret counter
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               branch,
  output logic               ir_write,
  output logic               iord,
  output logic               memread,
  output logic               MemWrite,
  output logic               memtoreg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal,
  output logic               mem_err,
  output logic [3:0]         state_o
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   instret
`endif
);
  localparam int CW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
  if (CNT_W < 1 || ALUOP_W < 2) begin : g_bad_param
    $error("multicycle_control_unit: CNT_W must be >= 1 and ALUOP_W >= 2");
  end
  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          wt, tmo, ill;
  ctrl_t         ctrl;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic          retire;
`endif
  ctrl_out_decode u_dec (.state(state), .mem_ready(mem_ready), .ctrl(ctrl));
  // Next state, timeout abort and illegal-opcode detection
  always_comb begin
    wt  = is_wait(state);
    tmo = (MEM_TIMEOUT != 0) && wt && !mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
    ill = state == DECODE && !(opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH});
    nxt = state;
    case (state)
      FETCH:     nxt = tmo ? FETCH : mem_ready ? DECODE : FETCH;
      DECODE:    nxt = opcode == OP_R ? EXEC_R :
                       opcode == OP_I ? EXEC_I :
                       opcode == OP_LOAD || opcode == OP_STORE ? MEM_ADDR :
                       opcode == OP_BRANCH ? BRANCH : FETCH;
      EXEC_R:    nxt = WB_ALU;
      EXEC_I:    nxt = WB_ALU;
      WB_ALU:    nxt = FETCH;
      MEM_ADDR:  nxt = opcode == OP_LOAD ? MEM_READ : MEM_WRITE;
      MEM_READ:  nxt = mem_ready ? MEM_WB : tmo ? FETCH : MEM_READ;
      MEM_WB:    nxt = FETCH;
      MEM_WRITE: nxt = mem_ready || tmo ? FETCH : MEM_WRITE;
      BRANCH:    nxt = FETCH;
      default:   nxt = FETCH;
    endcase
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    retire = state inside {WB_ALU, MEM_WB, BRANCH} || (state == MEM_WRITE && mem_ready);
`endif
  end
  // State register, wait counter (cleared whenever not stalling in a wait state) and retire count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
      instret <= '0;
`endif
    end else begin
      state <= nxt;
      cnt   <= wt && !mem_ready && !tmo ? cnt + CW'(1) : '0;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
      if (retire) instret <= instret + CNT_W'(1);
`endif
    end
  end
  assign pc_write = rst_n & ctrl.pc_write;
  assign branch   = rst_n & ctrl.branch;
  assign ir_write = rst_n & ctrl.ir_write;
  assign iord     = rst_n & ctrl.iord;
  assign memread  = rst_n & ctrl.memread;
  assign MemWrite = rst_n & ctrl.mem_write;
  assign memtoreg = rst_n & ctrl.memtoreg;
  assign RegWrite = rst_n & ctrl.reg_write;
  assign ALUSrcA  = rst_n & ctrl.alu_src_a;
  assign ALUSrcB  = rst_n ? ctrl.alu_src_b : 2'b00;
  assign ALUOp    = rst_n ? ALUOP_W'(ctrl.alu_op) : '0;
  assign illegal  = rst_n & ill;
  assign mem_err  = rst_n & tmo;
  assign state_o  = rst_n ? state : FETCH;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench for the multi-cycle control unit
module tb_multicycle_control_unit;
  logic        clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [4:0]  opcode = 5'b0;
  logic        pc_write, branch, ir_write, iord, memread, MemWrite, memtoreg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic        illegal, mem_err;
  logic [3:0]  state_o;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] instret;
`endif
  logic [18:0] obs;
  int          n_vec = 0, n_bad = 0, exp_ret = 0;
  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t        sb[$];
  logic [18:0] fr, fn, ft, dc, di, xr, xi, wa, ma, mr, mb, mw, mt, br;
  always #5 clk = ~clk;
  multicycle_control_unit #(.ALUOP_W(2), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .ir_write(ir_write), .iord(iord),
    .memread(memread), .MemWrite(MemWrite), .memtoreg(memtoreg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal),
    .mem_err(mem_err), .state_o(state_o)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , .instret(instret)
`endif
  );
  assign obs = {state_o, pc_write, branch, ir_write, iord, memread, MemWrite, memtoreg,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, mem_err};
  // flags = {pc_write, branch, ir_write, iord, memread, MemWrite, memtoreg, RegWrite, ALUSrcA}
  function automatic logic [18:0] e(input logic [3:0] st, input logic [8:0] f,
                                    input logic [1:0] b, input logic [1:0] op,
                                    input logic ill, input logic me);
    return {st, f, b, op, ill, me};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [4:0] op, input logic rdy, input logic [18:0] x);
    exp_t t;
    opcode = op;
    mem_ready = rdy;
    sb.push_back('{tag, 32'(x)});
    @(negedge clk);
    t = sb.pop_front();
    check(t.tag, 32'(obs), t.v);
    @(posedge clk);
    #1;
  endtask
  task automatic chk_ret(input string tag);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    check(tag, instret, 32'(exp_ret));
`endif
  endtask
  initial begin
    fr = e(4'd0, 9'b101010000, 2'b01, 2'b00, 1'b0, 1'b0);
    fn = e(4'd0, 9'b000010000, 2'b01, 2'b00, 1'b0, 1'b0);
    ft = e(4'd0, 9'b000010000, 2'b01, 2'b00, 1'b0, 1'b1);
    dc = e(4'd1, 9'b000000000, 2'b10, 2'b00, 1'b0, 1'b0);
    di = e(4'd1, 9'b000000000, 2'b10, 2'b00, 1'b1, 1'b0);
    xr = e(4'd2, 9'b000000001, 2'b00, 2'b10, 1'b0, 1'b0);
    xi = e(4'd3, 9'b000000001, 2'b10, 2'b11, 1'b0, 1'b0);
    wa = e(4'd4, 9'b000000010, 2'b00, 2'b00, 1'b0, 1'b0);
    ma = e(4'd5, 9'b000000001, 2'b10, 2'b00, 1'b0, 1'b0);
    mr = e(4'd6, 9'b000110000, 2'b00, 2'b00, 1'b0, 1'b0);
    mb = e(4'd7, 9'b000000110, 2'b00, 2'b00, 1'b0, 1'b0);
    mw = e(4'd8, 9'b000101000, 2'b00, 2'b00, 1'b0, 1'b0);
    mt = e(4'd8, 9'b000101000, 2'b00, 2'b00, 1'b0, 1'b1);
    br = e(4'd9, 9'b010000001, 2'b00, 2'b01, 1'b0, 1'b0);
    repeat (3) cyc("rst", 5'b01100, 1'b1, 19'd0);
    chk_ret("rst_ret");
    rst_n = 1'b1;
    cyc("r_f", 5'b01100, 1'b1, fr); cyc("r_d", 5'b01100, 1'b1, dc);
    cyc("r_x", 5'b01100, 1'b1, xr); cyc("r_wb", 5'b01100, 1'b1, wa); exp_ret++;
    cyc("i_f", 5'b00100, 1'b1, fr); cyc("i_d", 5'b00100, 1'b1, dc);
    cyc("i_x", 5'b00100, 1'b1, xi); cyc("i_wb", 5'b00100, 1'b1, wa); exp_ret++;
    cyc("b_f", 5'b11000, 1'b1, fr); cyc("b_d", 5'b11000, 1'b1, dc);
    cyc("b_br", 5'b11000, 1'b1, br); exp_ret++;
    cyc("s_f", 5'b01000, 1'b1, fr); cyc("s_d", 5'b01000, 1'b1, dc);
    cyc("s_ma", 5'b01000, 1'b1, ma); cyc("s_mw", 5'b01000, 1'b1, mw); exp_ret++;
    cyc("l_f", 5'b00000, 1'b1, fr); cyc("l_d", 5'b00000, 1'b1, dc); cyc("l_ma", 5'b00000, 1'b1, ma);
    repeat (3) cyc("l_wait", 5'b00000, 1'b0, mr);
    cyc("l_mr", 5'b00000, 1'b1, mr); cyc("l_wb", 5'b00000, 1'b1, mb); exp_ret++;
    chk_ret("ret5");
    cyc("fw_0", 5'b11111, 1'b0, fn); cyc("fw_1", 5'b11111, 1'b0, fn);
    cyc("fw_r", 5'b11111, 1'b1, fr); cyc("ill_d", 5'b11111, 1'b1, di);
    chk_ret("ill_ret");
    cyc("ill_f", 5'b01100, 1'b1, fr); cyc("ill_nd", 5'b01100, 1'b1, dc);
    cyc("ill_nx", 5'b01100, 1'b1, xr); cyc("ill_nwb", 5'b01100, 1'b1, wa); exp_ret++;
    cyc("st_f", 5'b01000, 1'b1, fr); cyc("st_d", 5'b01000, 1'b1, dc); cyc("st_ma", 5'b01000, 1'b1, ma);
    repeat (15) cyc("st_wait", 5'b01000, 1'b0, mw);
    cyc("st_tmo", 5'b01000, 1'b0, mt);
    chk_ret("st_tmo_ret");
    cyc("st_back", 5'b01100, 1'b0, fn);
    cyc("st_rf", 5'b01100, 1'b1, fr); cyc("st_rd", 5'b01100, 1'b1, dc);
    cyc("st_rx", 5'b01100, 1'b1, xr); cyc("st_rwb", 5'b01100, 1'b1, wa); exp_ret++;
    repeat (15) cyc("ft_wait", 5'b00100, 1'b0, fn);
    cyc("ft_tmo", 5'b00100, 1'b0, ft);
    cyc("ft_retry", 5'b00100, 1'b1, fr); cyc("ft_d", 5'b00100, 1'b1, dc);
    cyc("ft_x", 5'b00100, 1'b1, xi); cyc("ft_wb", 5'b00100, 1'b1, wa); exp_ret++;
    cyc("co_f", 5'b01000, 1'b1, fr); cyc("co_d", 5'b01000, 1'b1, dc); cyc("co_ma", 5'b01000, 1'b1, ma);
    repeat (15) cyc("co_wait", 5'b01000, 1'b0, mw);
    cyc("co_edge", 5'b01000, 1'b1, mw); exp_ret++;
    cyc("co_f2", 5'b01000, 1'b1, fr);
    chk_ret("ret9");
    cyc("mr_d", 5'b01000, 1'b1, dc); cyc("mr_ma", 5'b01000, 1'b1, ma);
    mem_ready = 1'b0;
    #3 check("mr_pre", 32'(obs), 32'(mw));
    #1 rst_n = 1'b0;
    #1 check("mr_rst", 32'(obs), 32'd0);
    exp_ret = 0;
    chk_ret("mr_ret");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("mr_after", 5'b01100, 1'b1, fr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequenced control for the multi-cycle RV32I datapath, replacing single-cycle opcode decode.
- Takes the latched instruction opcode and a memory-ready handshake, and steps through fetch/decode/execute/memory/writeback states.
- Drives Moore-style control strobes to the PC, IR, register file, ALU muxes and unified memory.
- Adds I-type ALU support, wait-state memory, a memory timeout, and illegal-opcode detection.

Parameters:
- ALUOP_W, 2, width of ALUOp output.
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready before abort; 0 disables the timeout.
- CNT_W, 32, width of the retire counter (PERF_CNT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  5  inst[6:2] from IR; stable from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- branch  out  1  conditional PC load (PC loads if ALU zero).
- ir_write  out  1  IR load.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memread  out  1  memory read request.
- MemWrite  out  1  memory write request.
- memtoreg  out  1  writeback select: 1=MDR, 0=ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=rs1.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm.
- ALUOp  out  ALUOP_W  00=add, 01=sub/branch, 10=R-funct, 11=I-funct.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- mem_err  out  1  one-cycle pulse on memory timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH, wait counter=0. All outputs are forced to 0 while rst_n is low, and state_o is forced to the FETCH encoding. Operation starts at the first clk edge after release.
- Outputs are a pure function of state, except pc_write and ir_write in FETCH, which are additionally gated by mem_ready.
- FETCH:
  - Drives memread=1, iord=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - On mem_ready: ir_write=1 and pc_write=1 in that cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute).
  - Next state by opcode: 01100→EXEC_R, 00100→EXEC_I, 00000 or 01000→MEM_ADDR, 11000→BRANCH.
  - Any other opcode: illegal=1 this cycle, next state FETCH. The PC has already advanced, so the instruction is skipped.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11; next state WB_ALU.
- WB_ALU: RegWrite=1, memtoreg=0; next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEM_READ for opcode 00000, MEM_WRITE for opcode 01000.
- MEM_READ: memread=1, iord=1, held until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, memtoreg=1; next state FETCH.
- MEM_WRITE: MemWrite=1, iord=1, held until mem_ready, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, branch=1; next state FETCH.
- Wait counter (FETCH, MEM_READ, MEM_WRITE):
  - Clears on entry to each wait state and increments each cycle mem_ready=0.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT−1 with mem_ready still 0: mem_err=1 for one cycle, next state FETCH.
  - If a timeout abort happens in FETCH, the PC is not advanced and fetch is retried.
  - If mem_ready and the timeout coincide, mem_ready wins and there is no mem_err.
- Cycle counts with mem_ready tied high: R/I-type 4 cycles, load 5, store 4, branch 3.
- Reset asserted mid-instruction aborts immediately. No partial register or memory write may occur after the reset edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output instret [CNT_W-1:0], reset to 0.
  - Increments by 1 on every transition into FETCH from WB_ALU, MEM_WB, MEM_WRITE or BRANCH.
  - Does not increment on illegal or mem_err exits.
  - Wraps modulo 2^CNT_W.
- Undefined: no port, no counter logic.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH);
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALUOp and ALUSrcB encodings.
- One sub-module, ctrl_out_decode: combinational state→control-word decoder. The top level keeps the state register, next-state logic, wait counter and optional counter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with clk running → all outputs 0, state_o=FETCH. After release with mem_ready=1 → ir_write=1 and pc_write=1 on the first cycle.
- R-type: opcode=01100, mem_ready=1 → states FETCH, DECODE, EXEC_R, WB_ALU; RegWrite=1 only in cycle 4; ALUOp=10 in cycle 3.
- Load with wait: opcode=00000, mem_ready low 3 cycles in MEM_READ → memread and iord held 4 cycles, then MEM_WB with memtoreg=1 and RegWrite=1; total 8 cycles.
- Timeout: MEM_TIMEOUT=16, store, mem_ready held 0 → mem_err pulses on the 16th MEM_WRITE cycle, returns to FETCH, MemWrite deasserts.
- Illegal: opcode=11111 → illegal=1 for exactly one cycle in DECODE, then FETCH. With MULTICYCLE_CTRL_PERF_CNT_EN, instret is unchanged.
- Mid-operation reset: assert rst_n=0 during MEM_WRITE → MemWrite drops to 0 asynchronously before the next clk edge, and state_o=FETCH.
